// File: rtl/mul_pkg.sv
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared defaults and FSM state encoding for the iterative multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_signfix.sv
// ============================================================================
// Module   : mul_signfix
// Purpose  : Operand magnitude extraction and 2*WIDTH-bit conditional negate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_signfix #(
    parameter int WIDTH = 32
) (
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    input  logic                 negate,
    input  logic [2*WIDTH-1:0]   val,
    output logic [2*WIDTH-1:0]   val_fixed
);

    localparam logic [WIDTH-1:0]   c_one_w = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_one_p = (2*WIDTH)'(1);

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign a_mag     = (is_signed & a[WIDTH-1]) ? (~a + c_one_w) : a;
    assign b_mag     = (is_signed & b[WIDTH-1]) ? (~b + c_one_w) : b;
    assign val_fixed = negate ? (~val + c_one_p) : val;

endmodule

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// Module   : mul_iter
// Purpose  : Iterative radix-2 shift-add multiplier with request/complete handshake.
//            Optional MUL_EARLY_EXIT_EN skips trailing shifts once the multiplier is zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 mul_clk,
    input  logic                 reset,
    input  logic                 mul,
    input  logic                 mul_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 complete
);

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    mul_state_t         r_state;
    mul_state_t         w_next_state;

    logic               r_signed;
    logic               r_xs;
    logic               r_ys;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;

    logic [WIDTH-1:0]   w_x_mag;
    logic [WIDTH-1:0]   w_y_mag;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mplier_step;
    logic [CNT_W-1:0]   w_cnt_step;
    logic               w_last;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_p_fixed;

    mul_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .is_signed (mul_signed),
        .a         (x),
        .b         (y),
        .a_mag     (w_x_mag),
        .b_mag     (w_y_mag),
        .negate    (w_neg),
        .val       (w_acc_next),
        .val_fixed (w_p_fixed)
    );

    // One shift-add step: conditional add with carry, then shift {carry, hi, lo} right.
    assign w_addend      = r_mplier[0] ? r_mcand : '0;
    assign w_sum         = {1'b0, r_acc_hi} + {1'b0, w_addend};
    assign w_acc_step    = {w_sum[WIDTH:1], w_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_mplier_step = {1'b0, r_mplier[WIDTH-1:1]};
    assign w_cnt_step    = r_cnt - c_cnt_one;
    assign w_neg         = r_signed & (r_xs ^ r_ys);

`ifdef MUL_EARLY_EXIT_EN
    // Remaining iterations would only shift zeros in, so collapse them into one barrel shift.
    assign w_last     = (r_cnt == c_cnt_one) || (w_mplier_step == '0);
    assign w_acc_next = w_acc_step >> w_cnt_step;
`else
    assign w_last     = (r_cnt == c_cnt_one);
    assign w_acc_next = w_acc_step;
`endif

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = mul ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (!mul) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = mul ? ST_HOLD : ST_IDLE;
            ST_HOLD: w_next_state = mul ? ST_HOLD : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == ST_BUSY) || (r_state == ST_DONE);
        complete = (r_state == ST_DONE);
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_signed <= 1'b0;
            r_xs     <= 1'b0;
            r_ys     <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mul) begin
                        r_signed <= mul_signed;
                        r_xs     <= x[WIDTH-1];
                        r_ys     <= y[WIDTH-1];
                        r_mcand  <= w_x_mag;
                        r_mplier <= w_y_mag;
                        r_acc_hi <= '0;
                        r_acc_lo <= '0;
                        r_cnt    <= c_cnt_init;
                    end
                end
                ST_BUSY: begin
                    if (mul) begin
                        r_acc_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_acc_lo <= w_acc_next[WIDTH-1:0];
                        r_mplier <= w_mplier_step;
                        r_cnt    <= w_cnt_step;
                        // Result is registered on entry to DONE so p is valid alongside complete.
                        if (w_last) begin
                            r_p <= w_p_fixed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign p = r_p;

endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
// ============================================================================
// Module   : tb_mul_iter
// Purpose  : Scoreboard-based self-checking bench for mul_iter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul;
    logic        mul_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] p;
    logic        busy;
    logic        complete;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_p = 64'd0;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mul_iter dut (
        .mul_clk    (clk),
        .reset      (reset),
        .mul        (mul),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .p          (p),
        .busy       (busy),
        .complete   (complete)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_prod(input logic [31:0] ax, input logic [31:0] ay,
                                               input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{ax[31]}}, ax} : {32'd0, ax};
        ye = s ? {{32{ay[31]}}, ay} : {32'd0, ay};
        return xe * ye;
    endfunction

    function automatic int model_lat(input logic [31:0] ay, input logic s);
        logic [31:0] m;
        int          it;
        m  = (s && ay[31]) ? (~ay + 32'd1) : ay;
        it = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) it = i + 1;
        end
        return EARLY ? (it + 1) : 33;
    endfunction

    task automatic run_op(input logic [31:0] ax, input logic [31:0] ay, input logic s,
                          input int hold, input bit scramble);
        exp_t e;
        int   k;
        bit   seen;
        e.prod = model_prod(ax, ay, s);
        e.lat  = model_lat(ay, s);
        sb.push_back(e);
        x = ax; y = ay; mul_signed = s; mul = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k <= 100) begin
            @(negedge clk);
            if (complete === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
                if (scramble) begin
                    x = $urandom; y = $urandom; mul_signed = 1'($urandom_range(0, 1));
                end
            end
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL op_timeout x=%h y=%h s=%0d: no complete within %0d cycles, required at %0d",
                     ax, ay, s, k, e.lat);
        end else begin
            if (p !== e.prod) begin
                errors++;
                $display("FAIL product x=%h y=%h s=%0d: got %h required %h", ax, ay, s, p, e.prod);
            end
            checks++;
            if (k !== e.lat) begin
                errors++;
                $display("FAIL latency x=%h y=%h s=%0d: got %0d required %0d", ax, ay, s, k, e.lat);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_at_complete: got %b required 1", busy);
            end
        end
        last_p = e.prod;
        repeat (hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (complete !== 1'b0 || p !== e.prod) begin
                errors++;
                $display("FAIL hold_stable: complete=%b p=%h required complete=0 p=%h",
                         complete, p, e.prod);
            end
        end
        @(posedge clk); #1;
        mul = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; mul = 1'b0; mul_signed = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (p !== 64'd0) begin errors++; $display("FAIL reset_p: got %h required 0", p); end
        checks++;
        if (complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b required 0", complete); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0);
    endtask

    task automatic test_signed;
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 0, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0, 1'b0);
        run_op(32'd0, 32'hFFFF_FFFB, 1'b1, 0, 1'b0);
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    endtask

    task automatic test_early_exit;
        run_op(32'h1234_5678, 32'd3, 1'b0, 0, 1'b0);
        run_op(32'h1234_5678, 32'hFFFF_FFFD, 1'b1, 0, 1'b0);
    endtask

    task automatic test_abort;
        x = 32'h0000_1234; y = 32'hF000_0001; mul_signed = 1'b0; mul = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        mul = 1'b0;
        @(negedge clk);
        checks++;
        if (complete !== 1'b0) begin errors++; $display("FAIL abort_c10_complete: got %b required 0", complete); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (complete !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_c11_idle: complete=%b busy=%b required 0 0", complete, busy);
        end
        checks++;
        if (p !== last_p) begin errors++; $display("FAIL abort_p_kept: got %h required %h", p, last_p); end
        @(posedge clk); #1;
        run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    endtask

    task automatic test_hold;
        run_op(32'h0000_0003, 32'h8765_4321, 1'b1, 5, 1'b0);
    endtask

    task automatic test_operand_change;
        run_op(32'h0BAD_F00D, 32'hFFFF_1234, 1'b1, 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        x = 32'h1111_2222; y = 32'h8000_0001; mul_signed = 1'b0; mul = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mul = 1'b0;
        @(negedge clk);
        checks++;
        if (p !== 64'd0) begin errors++; $display("FAIL midreset_p: got %h required 0", p); end
        checks++;
        if (complete !== 1'b0) begin errors++; $display("FAIL midreset_complete: got %b required 0", complete); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        last_p = 64'd0;
        @(posedge clk); #1;
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);
        end
        run_op(32'h0000_00FF, 32'h0000_0010, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_early_exit;
        test_abort;
        test_hold;
        test_operand_change;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
